// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared states, parameter limits and vector encoding for the truth-table sweeper
package tt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int N_IN_MIN  = 1;
  localparam int N_IN_MAX  = 8;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 65535;

  // Wide enough for the N_IN_MAX+1 bit index counter
  localparam int IDX_W_MAX = N_IN_MAX + 1;

  function automatic logic [IDX_W_MAX-1:0] gray_of(input logic [IDX_W_MAX-1:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// rtl/tt_sweep_checker_if.sv - control, DUT-facing and result signals of one sweeper
interface tt_sweep_checker_if #(
  parameter int N_IN = 2
);

  logic                   start;
  logic                   dut_out;
  logic [(1<<N_IN)-1:0]   expect_tt;
  logic [N_IN-1:0]        stim;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_fail;
  logic                   first_fail_vld;

  modport master (
    input  start, dut_out, expect_tt,
    output stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );

  modport slave (
    output start, dut_out, expect_tt,
    input  stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );

endinterface

// File: rtl/tt_dwell_timer.sv
// rtl/tt_dwell_timer.sv - per-vector dwell counter, flags the last cycle of each dwell
module tt_dwell_timer #(
  parameter int DWELL = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0] cnt;

  assign last = (cnt == W'(DWELL - 1));

  // Wraps on its own so back-to-back vectors need no explicit clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - sweeps all 2^N_IN input vectors through a DUT and checks its output
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 50,
  parameter int GRAY  = 1
) (
  input logic                 clk,
  input logic                 rst,
  tt_sweep_checker_if.master  bus
);

  localparam int IW = N_IN + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'((1 << N_IN) - 1);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_param_err
    $error("tt_sweep_checker: N_IN or DWELL out of range");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            ffv_q, ffv_d;
  logic            tmr_clr, tmr_en, tmr_last;
  logic [N_IN-1:0] vec_cur, vec_next;
  logic            mismatch;

  function automatic logic [N_IN-1:0] enc(input logic [IW-1:0] i);
    logic [IDX_W_MAX-1:0] w;
    w = IDX_W_MAX'(i);
    if (GRAY != 0) w = gray_of(w);
    return w[N_IN-1:0];
  endfunction

  assign vec_cur  = enc(idx_q);
  assign vec_next = enc(idx_q + IW'(1));
  assign mismatch = (bus.dut_out != bus.expect_tt[vec_cur]);

  tt_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    ff_d    = ff_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          stim_d  = enc('0);
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      S_RUN: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!ffv_q) begin
              ff_d  = vec_cur;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
            pass_d  = (err_d == '0);
          end else begin
            idx_d  = idx_q + IW'(1);
            stim_d = vec_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stim_q  <= '0;
      ff_q    <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      ff_q    <= ff_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
    end
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail     = ff_q;
  assign bus.first_fail_vld = ffv_q;

endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Parametrised, self-checking truth-table sweeper for the combinational lab circuits. On `start` it drives an N-bit stimulus bus through all 2^N input combinations in binary or Gray order, holds each vector for a programmable dwell, samples the DUT output at the end of each dwell, and compares it against a runtime-supplied expected truth table. It sits between the on-board controls and a schematic DUT, replacing hand-written fixed-delay stimulus with a synthesizable sweep that reports a mismatch count and the first failing vector.

## Interface
- `N_IN`, 2: number of DUT inputs; legal range 1..8.
- `DWELL`, 50: clock cycles each vector is held; legal range 1..65535.
- `GRAY`, 1: 1 = Gray-code sweep order (00, 01, 11, 10 for N_IN=2); 0 = binary order.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `dut_out` in 1: DUT output under test.
- `expect_tt` in 2^N_IN: expected output; bit v is the expected `dut_out` when `stim` == v. Must be held stable while `busy`.
- `stim` out N_IN: vector driven to the DUT.
- `busy` out 1: high while a sweep is running.
- `done` out 1: high from sweep completion until the next `start` or `rst`.
- `pass` out 1: `done` and `err_count` == 0.
- `err_count` out N_IN+1: number of mismatching vectors in the current or last sweep.
- `first_fail` out N_IN: vector value of the first mismatch.
- `first_fail_vld` out 1: `first_fail` is valid.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- Reset, from any state including mid-sweep:
  - state = IDLE.
  - `stim`, `busy`, `done`, `pass`, `err_count`, `first_fail` and `first_fail_vld` all = 0.
- IDLE or DONE with `start`=1:
  - go to RUN with index i=0, dwell count c=0.
  - `stim` = V(0); clear `err_count`, `first_fail`, `first_fail_vld` and `done`.
  - `busy` = 1.
- RUN, each cycle: c increments. When c == DWELL−1:
  - compare `dut_out` with `expect_tt[V(i)]`.
  - on mismatch: `err_count`++; if `first_fail_vld`=0, latch `first_fail` = V(i) and set `first_fail_vld`.
  - if i == 2^N_IN−1: go to DONE.
  - otherwise: i++, c=0, `stim` = V(i+1).
- V(i) = i ^ (i>>1) when GRAY=1, else i. The index counter i is N_IN+1 bits wide so it does not wrap at the last vector.
- Entering DONE:
  - `busy` = 0, `done` = 1, `stim` = 0.
  - `pass` = (final `err_count` == 0).
  - results hold until `start` or `rst`.
- `start` is ignored while in RUN.
- `err_count` cannot overflow: its maximum is 2^N_IN.

## Timing
- `start` is sampled high at edge t0.
- Vector k is on `stim` for cycles t0+1+k·DWELL through t0+(k+1)·DWELL.
- Each vector is sampled in the last cycle of its dwell. The DUT therefore has DWELL−1 cycles to settle; with DWELL=1 the DUT must be combinational within one cycle.
- `done`/`pass` rise at t0+1+2^N_IN·DWELL. `busy` falls on the same edge.
- `err_count` and `first_fail` update one cycle after the sampling cycle.
- `start` asserted in the same cycle that DONE is entered is ignored. `start` asserted in DONE restarts on the next edge.

## Structure
- Shared package `tt_pkg`:
  - state encoding constants `S_IDLE`, `S_RUN`, `S_DONE`.
  - function `gray_of(i)`.
  - parameter-range limits.
- One sub-module, `tt_dwell_timer`:
  - parametrised by DWELL.
  - inputs `clr`/`en`; output `last` when c == DWELL−1.
  - width = clog2(DWELL), minimum 1.
- Top level holds the FSM, the index counter, the vector encoding and the checker registers.

## Test plan
- Reset and idle: N_IN=2, DWELL=50, GRAY=1; hold `rst` 3 cycles. Expect all outputs 0 and `stim` stays 0 with no `start`.
- Gray sweep order: `start` 1 cycle, `expect_tt`=4'b0110, DUT = a^b.
  - `stim` must read 00, 01, 11, 10, each for exactly 50 cycles.
  - `done` at t0+201; `pass`=1, `err_count`=0, `first_fail_vld`=0.
- Binary sweep with a fault: GRAY=0, DUT = AND, `expect_tt`=4'b0110.
  - Mismatches occur at vectors 01, 10 and 11.
  - Expect `err_count`=3, `first_fail`=01, `first_fail_vld`=1, `pass`=0.
- Minimum dwell and width: N_IN=4, DWELL=1, DUT = parity, `expect_tt`=16'h6996.
  - 16 consecutive vectors; `done` at t0+17; `pass`=1.
- Reset mid-sweep: `rst` at cycle t0+120 of an N_IN=2, DWELL=50 run. Expect IDLE, `stim`=0 and `err_count`=0 on the next cycle.
- Restart and ignored start:
  - pulse `start` during RUN: no effect on timing or `stim`.
  - after `done`, pulse `start` with a different `expect_tt`: `done` clears and the sweep restarts at V(0) on the next edge.
